// File: rtl/pif_ram_arbiter_if.sv
// Bus bundle between the 6502 decode, the joybus DMA engine and PIF RAM port A.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface pif_ram_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_wr;
    logic              dma_lock;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic              dma_gnt;
    logic [7:0]        dma_rdata;
    logic              dma_rvalid;

    logic              ram_oe;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_q;
    logic              ram_valid;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
        input  ram_q, ram_valid,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        output dma_gnt, dma_rdata, dma_rvalid,
        output ram_oe, ram_wren, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_wr, dma_lock, dma_addr, dma_wdata,
        output ram_q, ram_valid,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  ram_oe, ram_wren, ram_addr, ram_wdata
    );
endinterface

// File: rtl/pif_ram_arbiter.sv
// Two-requester arbiter (6502 vs joybus DMA) for PIF RAM port A with burst lock and read-return tagging.
// Optional DMA anti-starvation counter is enabled by defining PIF_ARB_STARVE_EN.
module pif_ram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             reset,
    pif_ram_arbiter_if.slave bus
);
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_CPU  = 2'b01;
    localparam logic [1:0] TAG_DMA  = 2'b10;

    if (STARVE_LIMIT < 1 || ADDR_W < 1) begin : g_param_check
        $error("pif_ram_arbiter: STARVE_LIMIT and ADDR_W must be at least 1");
    end

    logic [0:0]        state;
    logic [1:0]        tag_p1;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              dma_first;
    logic              rd_issue;
    logic [ADDR_W-1:0] addr_mux;

`ifdef PIF_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign dma_first = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts denied DMA cycles; saturates so DMA keeps its one forced win until granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dma_gnt) begin
            starve_cnt <= '0;
        end else if (bus.dma_req && !dma_first) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign dma_first = 1'b0;
`endif

    // Lock only holds while the engine keeps both req and lock; otherwise normal priority.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (state == ST_LOCK && bus.dma_req && bus.dma_lock) begin
                dma_gnt = 1'b1;
            end else if (bus.dma_req && (!bus.cpu_req || dma_first)) begin
                dma_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        addr_mux = '0;
        if (cpu_gnt) begin
            addr_mux = bus.cpu_addr;
        end else if (dma_gnt) begin
            addr_mux = bus.dma_addr;
        end
    end

    assign bus.ram_oe    = cpu_gnt | dma_gnt;
    assign bus.ram_wren  = (cpu_gnt & bus.cpu_wr) | (dma_gnt & bus.dma_wr);
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = cpu_gnt ? bus.cpu_wdata : (dma_gnt ? bus.dma_wdata : 8'h00);
    assign bus.cpu_ready = ~bus.cpu_req | cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;

    assign rd_issue = bus.ram_oe & ~bus.ram_wren;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ARB;
        end else if (dma_gnt && bus.dma_lock) begin
            state <= ST_LOCK;
        end else begin
            state <= ST_ARB;
        end
    end

    // Issue stage -> return stage: tag follows each read to its 1-cycle RAM response.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_p1 <= TAG_NONE;
        end else if (rd_issue) begin
            tag_p1 <= cpu_gnt ? TAG_CPU : TAG_DMA;
        end else begin
            tag_p1 <= TAG_NONE;
        end
    end

    // Gated by reset so a read already in flight when reset hits never returns.
    assign bus.cpu_rvalid = ~reset & bus.ram_valid & (tag_p1 == TAG_CPU);
    assign bus.dma_rvalid = ~reset & bus.ram_valid & (tag_p1 == TAG_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_q : 8'h00;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.ram_q : 8'h00;
endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Directed and random bench for pif_ram_arbiter against a cycle-level behavioural model of its rules.
module tb_pif_ram_arbiter;
    localparam int AW    = 11;
    localparam int LIMIT = 4;
`ifdef PIF_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ram_init;
    logic spur;

    always #5 clk = ~clk;

    pif_ram_arbiter_if #(.ADDR_W(AW)) bus ();

    pif_ram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-cycle synchronous RAM on port A
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] q_r;
    logic       valid_r;

    always_ff @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= 8'(i * 7 + 3);
        end else if (bus.ram_oe && bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        q_r     <= mem[bus.ram_addr];
        valid_r <= bus.ram_oe && !bus.ram_wren;
    end

    assign bus.ram_q     = q_r;
    assign bus.ram_valid = valid_r | spur;

    // Reference model state
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [0:(1<<AW)-1];
    bit         locked;
    int         pend;        // 0 none, 1 cpu, 2 dma
    logic [7:0] pend_data;
    int         starve;
    int         gcount;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rs, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [7:0] cd, input logic dr, input logic dw, input logic dl,
                       input logic [AW-1:0] da, input logic [7:0] dd, input logic sp);
        bit cg, dg, ev_c, ev_d;
        bit exp_wren;
        logic [AW-1:0] exp_addr;
        logic [7:0] exp_wd;
        reset = rs; spur = sp; ram_init = 1'b0;
        bus.cpu_req = cr; bus.cpu_wr = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_wr = dw; bus.dma_lock = dl; bus.dma_addr = da; bus.dma_wdata = dd;

        cg = 0; dg = 0;
        if (!rs) begin
            if (locked && dr && dl) dg = 1;
            else if (dr && (!cr || (STARVE_ON && starve >= LIMIT))) dg = 1;
            else if (cr) cg = 1;
        end
        exp_wren = cg ? cw : (dg ? dw : 1'b0);
        exp_addr = cg ? ca : (dg ? da : '0);
        exp_wd   = cg ? cd : (dg ? dd : 8'h00);

        @(negedge clk);
        chk("cpu_ready", 16'(bus.cpu_ready), 16'(!cr || cg));
        chk("dma_gnt", 16'(bus.dma_gnt), 16'(dg));
        chk("ram_oe", 16'(bus.ram_oe), 16'(cg || dg));
        chk("ram_wren", 16'(bus.ram_wren), 16'(exp_wren));
        chk("ram_addr", 16'(bus.ram_addr), 16'(exp_addr));
        chk("ram_wdata", 16'(bus.ram_wdata), 16'(exp_wd));
        ev_c = !rs && pend == 1 && bus.ram_valid;
        ev_d = !rs && pend == 2 && bus.ram_valid;
        chk("cpu_rvalid", 16'(bus.cpu_rvalid), 16'(ev_c));
        chk("cpu_rdata", 16'(bus.cpu_rdata), ev_c ? 16'(pend_data) : 16'h0);
        chk("dma_rvalid", 16'(bus.dma_rvalid), 16'(ev_d));
        chk("dma_rdata", 16'(bus.dma_rdata), ev_d ? 16'(pend_data) : 16'h0);
        if (bus.dma_gnt) gcount++;

        @(posedge clk);
        if (rs) begin
            locked = 0; pend = 0; starve = 0;
        end else begin
            locked = dg && dl;
            pend = 0;
            if (cg || dg) begin
                if (exp_wren) ref_mem[exp_addr] = exp_wd;
                else begin
                    pend = cg ? 1 : 2;
                    pend_data = ref_mem[exp_addr];
                end
            end
            if (dg) starve = 0;
            else if (dr && starve < LIMIT) starve++;
        end
        #1;
    endtask

    task automatic idle(input logic rs);
        cyc(rs, 0, 0, '0, 8'h00, 0, 0, 0, '0, 8'h00, 0);
    endtask

    initial begin
        logic [AW-1:0] ra, rb;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 8'(i * 7 + 3);
        locked = 0; pend = 0; starve = 0; gcount = 0;
        reset = 1'b1; ram_init = 1'b1; spur = 1'b0;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_wr = 0; bus.dma_lock = 0; bus.dma_addr = '0; bus.dma_wdata = 0;
        @(posedge clk); #1;

        // Reset: grants held off, cpu_ready = ~cpu_req, lock request ignored
        cyc(1, 1, 0, 11'h010, 8'h00, 1, 0, 1, 11'h020, 8'h00, 0);
        cyc(1, 0, 0, 11'h010, 8'h00, 1, 1, 1, 11'h021, 8'h11, 1);
        idle(0);

        // Simultaneous request: CPU wins, read data returns next cycle
        cyc(0, 1, 0, 11'h010, 8'h00, 1, 0, 0, 11'h020, 8'h00, 0);
        idle(0);

        // Lock burst 0x7C0..0x7C7 with CPU pending, then CPU on lock drop
        gcount = 0;
        cyc(0, 0, 0, 11'h100, 8'h00, 1, 1, 1, 11'h7C0, 8'hA0, 0);
        for (int i = 1; i < 8; i++)
            cyc(0, 1, 0, 11'h100, 8'h00, 1, 1, 1, 11'(11'h7C0 + i), 8'(8'hA0 + i), 0);
        chk("burst_gnt_count", 16'(gcount), 16'd8);
        cyc(0, 1, 0, 11'h100, 8'h00, 1, 1, 0, 11'h7C8, 8'hA8, 0);
        idle(0);

        // Interleaved reads of burst data, no cross-delivery
        cyc(0, 1, 0, 11'h7C3, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0);
        cyc(0, 0, 0, 11'h000, 8'h00, 1, 0, 0, 11'h7C5, 8'h00, 0);
        idle(0);

        // Starvation window: CPU always requesting, DMA pending
        gcount = 0;
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 0, 11'(11'h200 + i), 8'h00, 1, 0, 0, 11'h300, 8'h00, 0);
        chk("starve_dma_gnts", 16'(gcount), STARVE_ON ? 16'd1 : 16'd0);
        cyc(0, 0, 0, 11'h000, 8'h00, 1, 0, 0, 11'h300, 8'h00, 0);
        idle(0);

        // Reset on the issue cycle of a CPU read, then reset after an issued read
        cyc(1, 1, 0, 11'h044, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0);
        idle(1);
        idle(0);
        cyc(0, 1, 0, 11'h045, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0);
        idle(1);
        idle(0);

        // DMA write followed by a spurious ram_valid
        cyc(0, 0, 0, 11'h000, 8'h00, 1, 1, 0, 11'h055, 8'h5E, 0);
        cyc(0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1);
        idle(0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ra = AW'($urandom);
            rb = AW'($urandom);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                ra, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0, rb, 8'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pif_ram_arbiter.md
PIF_RAM_ARBITER -- requirements
Module: pif_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, PIF RAM byte-address width.
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive denied DMA cycles before the DMA requester is forced through.
REQ-003 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Ports cpu_req / cpu_wr, input, 1 each, 6502 access strobe from the address decode and its write qualifier.
REQ-006 Ports cpu_addr / cpu_wdata, input, ADDR_W / 8, 6502 address and write byte.
REQ-007 Ports cpu_ready, output, 1, to the 6502 RDY; cpu_rdata, output, 8; cpu_rvalid, output, 1.
REQ-008 Ports dma_req / dma_wr / dma_lock, input, 1 each, joybus engine request, write qualifier and burst lock.
REQ-009 Ports dma_addr / dma_wdata, input, ADDR_W / 8, DMA address and write byte.
REQ-010 Ports dma_gnt, output, 1; dma_rdata, output, 8; dma_rvalid, output, 1.
REQ-011 Ports ram_oe / ram_wren, output, 1 each; ram_addr, output, ADDR_W; ram_wdata, output, 8; ram_q, input, 8; ram_valid, input, 1. These drive PIF RAM port A.

Function
REQ-012 Grant: at most one requester per cycle. cpu_gnt / dma_gnt are combinational from the requests and registered state.
REQ-013 Issue: ram_oe = cpu_gnt | dma_gnt. ram_wren, ram_addr and ram_wdata mux from the granted requester; all are 0 when no grant is given.
REQ-014 cpu_ready = ~cpu_req | cpu_gnt; the 6502 holds its address while stalled.
REQ-015 State ARB default priority: CPU wins on a same-cycle request. DMA is granted when cpu_req=0.
REQ-016 ARB to LOCK when dma_gnt=1 and dma_lock=1 in the same cycle.
REQ-017 In LOCK, DMA is granted whenever dma_req=1; the CPU is denied and cpu_ready=0 while cpu_req=1.
REQ-018 LOCK to ARB on the first cycle with dma_lock=0 or dma_req=0; arbitration for that cycle follows ARB rules.
REQ-019 Return tag: a registered 2-bit tag {none, cpu, dma} captures the owner of each read issue (ram_oe=1, ram_wren=0); writes and idle cycles load none.
REQ-020 Read return: ram_valid with tag cpu drives cpu_rvalid=1 and cpu_rdata=ram_q. Tag dma drives dma_rvalid / dma_rdata the same way. Tag none means ram_valid is ignored.
REQ-021 Read latency: issue at cycle N gives rvalid at N+1, given a 1-cycle RAM.
REQ-022 Back-to-back issues are allowed every cycle; the tag pipeline supports a new read every cycle.
REQ-023 Unselected rdata outputs hold 8'h00.

Reset
REQ-024 While reset=1: state=ARB, tag=none, starvation count=0, and every output is 0 except cpu_ready, which follows REQ-014 with a denied grant (cpu_ready=~cpu_req).
REQ-025 A read in flight when reset asserts produces no rvalid on either side after reset.
REQ-026 A DMA lock active at reset is dropped; the first post-reset cycle uses ARB rules.

Configuration
REQ-027 Macro PIF_ARB_STARVE_EN.
- Defined: a counter of width clog2(STARVE_LIMIT+1) increments each cycle with dma_req=1 and dma_gnt=0, and saturates at STARVE_LIMIT. At STARVE_LIMIT, DMA wins the next arbitration over the CPU for one access. The counter clears on any dma_gnt.
- Undefined: no counter exists and CPU priority in ARB is absolute.

Verification
REQ-028 Simultaneous request: cpu_req=1 read 0x010, dma_req=1 in ARB -> cpu_gnt, dma_gnt=0, ram_addr=0x010. Next cycle cpu_rvalid=1 with cpu_rdata equal to the RAM byte.
REQ-029 Lock burst: DMA writes 0x7C0..0x7C7 with dma_lock=1 while cpu_req=1 -> 8 consecutive dma_gnt, cpu_ready=0 throughout. The CPU is granted on the cycle dma_lock drops.
REQ-030 Interleaved reads: CPU read at N, DMA read at N+1 -> cpu_rvalid at N+1 and dma_rvalid at N+2, each with the correct data and no cross-delivery.
REQ-031 Starvation, PIF_ARB_STARVE_EN defined, STARVE_LIMIT=4: CPU requests every cycle with DMA pending -> dma_gnt on the 5th cycle, then the CPU resumes. Undefined: dma_gnt never asserts.
REQ-032 Reset during a CPU read, asserted on the issue cycle -> cpu_rvalid stays 0, state=ARB and all grants are 0 until reset drops.
REQ-033 Write return suppressed: a DMA write, then a spurious ram_valid -> cpu_rvalid=0 and dma_rvalid=0.
